// File: rtl/tap_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tap_controller
//
// IEEE 1149.1 TAP state machine. Follows tms on posedge tck through the
// 16-state TAP sequence. It generates the capture/shift/update controls, the
// gated clockDR/clockIR strobes for the data and instruction registers, and
// the IR/DR path select and TDO enable for the output mux.
//
// Ports
//   tck        in   TAP clock (posedge and negedge flops, single domain)
//   reset      in   synchronous active-high reset, forces Test-Logic-Reset
//   tms        in   test mode select, sampled on posedge tck
//   state      out  [3:0] current TAP state (registered, fixed encoding)
//   tlr        out  high in Test-Logic-Reset
//   captureDR  out  high in Capture-DR
//   shiftDR    out  high in Shift-DR
//   captureIR  out  high in Capture-IR
//   shiftIR    out  high in Shift-IR
//   updateDR   out  negedge-registered, one tck period from negedge in Update-DR
//   updateIR   out  negedge-registered, one tck period from negedge in Update-IR
//   clockDR    out  tck gated to Capture-DR / Shift-DR
//   clockIR    out  tck gated to Capture-IR / Shift-IR
//   select     out  1 = IR path to TDO (Select-IR-Scan .. Update-IR), 0 = DR path
//   tdo_en     out  negedge-registered, high while in Shift-DR / Shift-IR
// -----------------------------------------------------------------------------
module tap_controller (
    input  logic       tck,
    input  logic       reset,
    input  logic       tms,
    output logic [3:0] state,
    output logic       tlr,
    output logic       captureDR,
    output logic       shiftDR,
    output logic       captureIR,
    output logic       shiftIR,
    output logic       updateDR,
    output logic       updateIR,
    output logic       clockDR,
    output logic       clockIR,
    output logic       select,
    output logic       tdo_en
);

    // The encoding is part of the interface: downstream logic and debuggers
    // read these codes directly from the state port.
    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SH_DR    = 4'h2,
        EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3,
        EX2_DR   = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SH_IR    = 4'hA,
        EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB,
        EX2_IR   = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_t;

    tap_state_t cur;
    logic       en_dr;
    logic       en_ir;

    // NOTE: state registers use non-blocking assignments so that every flop
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge tck) begin
        if (reset) begin
            cur <= TLR;
        end else begin
            unique case (cur)
                TLR:      cur <= tms ? TLR      : RTI;
                RTI:      cur <= tms ? SEL_DR   : RTI;
                SEL_DR:   cur <= tms ? SEL_IR   : CAP_DR;
                CAP_DR:   cur <= tms ? EX1_DR   : SH_DR;
                SH_DR:    cur <= tms ? EX1_DR   : SH_DR;
                EX1_DR:   cur <= tms ? UPD_DR   : PAUSE_DR;
                PAUSE_DR: cur <= tms ? EX2_DR   : PAUSE_DR;
                EX2_DR:   cur <= tms ? UPD_DR   : SH_DR;
                UPD_DR:   cur <= tms ? SEL_DR   : RTI;
                SEL_IR:   cur <= tms ? TLR      : CAP_IR;
                CAP_IR:   cur <= tms ? EX1_IR   : SH_IR;
                SH_IR:    cur <= tms ? EX1_IR   : SH_IR;
                EX1_IR:   cur <= tms ? UPD_IR   : PAUSE_IR;
                PAUSE_IR: cur <= tms ? EX2_IR   : PAUSE_IR;
                EX2_IR:   cur <= tms ? UPD_IR   : SH_IR;
                UPD_IR:   cur <= tms ? SEL_DR   : RTI;
            endcase
        end
    end

    // Level controls are plain decodes of the registered state.
    assign state     = cur;
    assign tlr       = (cur == TLR);
    assign captureDR = (cur == CAP_DR);
    assign shiftDR   = (cur == SH_DR);
    assign captureIR = (cur == CAP_IR);
    assign shiftIR   = (cur == SH_IR);
    assign select    = cur inside {SEL_IR, CAP_IR, SH_IR, EX1_IR,
                                   PAUSE_IR, EX2_IR, UPD_IR};

    // NOTE: the clock enables change only on negedge, while tck is low, so
    // the AND gates below never clip or glitch a high phase of tck. The
    // posedge of a gated clock therefore coincides with the tck posedge that
    // leaves the enabling state.
    always_ff @(negedge tck) begin
        if (reset) begin
            en_dr    <= 1'b0;
            en_ir    <= 1'b0;
            updateDR <= 1'b0;
            updateIR <= 1'b0;
            tdo_en   <= 1'b0;
        end else begin
            en_dr    <= (cur == CAP_DR) || (cur == SH_DR);
            en_ir    <= (cur == CAP_IR) || (cur == SH_IR);
            updateDR <= (cur == UPD_DR);
            updateIR <= (cur == UPD_IR);
            tdo_en   <= (cur == SH_DR) || (cur == SH_IR);
        end
    end

    assign clockDR = tck & en_dr;
    assign clockIR = tck & en_ir;

endmodule

// File: tb/tb_tap_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_tap_controller
//
// Self-checking bench for tap_controller. A reference model holds the TAP
// transition table as two lookup arrays (next on tms=0 / tms=1) and derives
// every expected output from the current model state. A 32-bit data register
// clocked by clockDR is attached to observe the capture/shift behaviour.
// -----------------------------------------------------------------------------
module tb_tap_controller;

    // State codes of the TAP sequence.
    localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SELDR = 4'h7,
        S_CAPDR = 4'h6, S_SHDR = 4'h2, S_EX1DR = 4'h1, S_PAUSEDR = 4'h3,
        S_EX2DR = 4'h0, S_UPDDR = 4'h5, S_SELIR = 4'h4, S_CAPIR = 4'hE,
        S_SHIR = 4'hA, S_EX1IR = 4'h9, S_PAUSEIR = 4'hB, S_EX2IR = 4'h8,
        S_UPDIR = 4'hD;

    logic       tck   = 1'b1;
    logic       reset = 1'b1;
    logic       tms   = 1'b0;
    logic [3:0] state;
    logic       tlr, captureDR, shiftDR, captureIR, shiftIR;
    logic       updateDR, updateIR, clockDR, clockIR, select, tdo_en;

    tap_controller dut (
        .tck       (tck),
        .reset     (reset),
        .tms       (tms),
        .state     (state),
        .tlr       (tlr),
        .captureDR (captureDR),
        .shiftDR   (shiftDR),
        .captureIR (captureIR),
        .shiftIR   (shiftIR),
        .updateDR  (updateDR),
        .updateIR  (updateIR),
        .clockDR   (clockDR),
        .clockIR   (clockIR),
        .select    (select),
        .tdo_en    (tdo_en)
    );

    always #5 tck = ~tck;

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    logic [3:0] nxt0 [16];
    logic [3:0] nxt1 [16];
    logic [3:0] m_state = S_TLR;
    logic       exp_en_dr = 1'b0;
    logic       exp_en_ir = 1'b0;

    task automatic link(input logic [3:0] s, input logic [3:0] n0, input logic [3:0] n1);
        nxt0[s] = n0;
        nxt1[s] = n1;
    endtask

    function automatic logic is_ir_side(input logic [3:0] s);
        return s == S_SELIR || s == S_CAPIR || s == S_SHIR || s == S_EX1IR ||
               s == S_PAUSEIR || s == S_EX2IR || s == S_UPDIR;
    endfunction

    // ---------------- attached data register ----------------
    logic        cap_s = 1'b0, sh_s = 1'b0;
    logic [31:0] dr_sr;
    logic [31:0] dr_out;
    int          cnt_dr = 0, cnt_ir = 0, caps = 0;

    // Controls are stable at negedge; the register uses those sampled values.
    always @(negedge tck) begin
        cap_s <= captureDR;
        sh_s  <= shiftDR;
    end

    always @(posedge clockDR) begin
        cnt_dr <= cnt_dr + 1;
        if (cap_s) begin
            dr_sr <= 32'h1;
            caps  <= caps + 1;
        end else if (sh_s) begin
            dr_out <= {dr_sr[0], dr_out[31:1]};
            dr_sr  <= {1'b0, dr_sr[31:1]};
        end
    end

    always @(posedge clockIR) cnt_ir <= cnt_ir + 1;

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (model state %0h)", tag, obs, exp, m_state);
        end
    endtask

    int prev_dr, prev_ir;

    // One tck cycle: check negedge-registered outputs, drive inputs, then
    // check state, decodes and gated-clock pulses after the posedge.
    task automatic step(input logic t, input logic r);
        @(negedge tck);
        #1;
        exp_en_dr = !reset && (m_state == S_CAPDR || m_state == S_SHDR);
        exp_en_ir = !reset && (m_state == S_CAPIR || m_state == S_SHIR);
        chk("tdo_en",   32'(tdo_en),   32'(!reset && (m_state == S_SHDR || m_state == S_SHIR)));
        chk("updateDR", 32'(updateDR), 32'(!reset && m_state == S_UPDDR));
        chk("updateIR", 32'(updateIR), 32'(!reset && m_state == S_UPDIR));
        #1;
        tms     = t;
        reset   = r;
        prev_dr = cnt_dr;
        prev_ir = cnt_ir;
        @(posedge tck);
        #1;
        m_state = r ? S_TLR : (t ? nxt1[m_state] : nxt0[m_state]);
        chk("state",     32'(state),     32'(m_state));
        chk("tlr",       32'(tlr),       32'(m_state == S_TLR));
        chk("captureDR", 32'(captureDR), 32'(m_state == S_CAPDR));
        chk("shiftDR",   32'(shiftDR),   32'(m_state == S_SHDR));
        chk("captureIR", 32'(captureIR), 32'(m_state == S_CAPIR));
        chk("shiftIR",   32'(shiftIR),   32'(m_state == S_SHIR));
        chk("select",    32'(select),    32'(is_ir_side(m_state)));
        chk("clockDR_pulse", 32'(cnt_dr - prev_dr), 32'(exp_en_dr));
        chk("clockIR_pulse", 32'(cnt_ir - prev_ir), 32'(exp_en_ir));
    endtask

    // tms paths from Test-Logic-Reset to each state, applied left to right.
    string paths [16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_dr, base_ir, base_caps;
        int upd_seen;

        link(S_TLR,     S_RTI,     S_TLR);
        link(S_RTI,     S_RTI,     S_SELDR);
        link(S_SELDR,   S_CAPDR,   S_SELIR);
        link(S_CAPDR,   S_SHDR,    S_EX1DR);
        link(S_SHDR,    S_SHDR,    S_EX1DR);
        link(S_EX1DR,   S_PAUSEDR, S_UPDDR);
        link(S_PAUSEDR, S_PAUSEDR, S_EX2DR);
        link(S_EX2DR,   S_SHDR,    S_UPDDR);
        link(S_UPDDR,   S_RTI,     S_SELDR);
        link(S_SELIR,   S_CAPIR,   S_TLR);
        link(S_CAPIR,   S_SHIR,    S_EX1IR);
        link(S_SHIR,    S_SHIR,    S_EX1IR);
        link(S_EX1IR,   S_PAUSEIR, S_UPDIR);
        link(S_PAUSEIR, S_PAUSEIR, S_EX2IR);
        link(S_EX2IR,   S_SHIR,    S_UPDIR);
        link(S_UPDIR,   S_RTI,     S_SELDR);

        paths[S_TLR]     = "";        paths[S_RTI]     = "0";
        paths[S_SELDR]   = "01";      paths[S_CAPDR]   = "010";
        paths[S_SHDR]    = "0100";    paths[S_EX1DR]   = "0101";
        paths[S_PAUSEDR] = "01010";   paths[S_EX2DR]   = "010101";
        paths[S_UPDDR]   = "01011";   paths[S_SELIR]   = "011";
        paths[S_CAPIR]   = "0110";    paths[S_SHIR]    = "01100";
        paths[S_EX1IR]   = "01101";   paths[S_PAUSEIR] = "011010";
        paths[S_EX2IR]   = "0110101"; paths[S_UPDIR]   = "011011";

        // Reset held for two cycles.
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);

        // DR scan: capture then 32 shifts of a 32-bit register.
        base_dr   = cnt_dr;
        base_caps = caps;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        repeat (31) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("scan_dr_pulses",   32'(cnt_dr - base_dr), 32'd33);
        chk("scan_dr_captures", 32'(caps - base_caps), 32'd1);
        chk("scan_dr_tdo",      dr_out,                32'h1);

        // Back into Shift-DR through Pause/Exit2, then the pause sequence.
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        base_dr = cnt_dr;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("pause_dr_pulses", 32'(cnt_dr - base_dr), 32'd2);

        // IR scan from Run-Test/Idle.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        base_dr = cnt_dr;
        base_ir = cnt_ir;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("ir_scan_ir_pulses", 32'(cnt_ir - base_ir), 32'd2);
        chk("ir_scan_dr_pulses", 32'(cnt_dr - base_dr), 32'd0);

        // Five tms=1 reach Test-Logic-Reset from every state.
        for (int s = 0; s < 16; s++) begin
            step(1'b0, 1'b1);
            for (int i = 0; i < paths[s].len(); i++)
                step(paths[s][i] == "1", 1'b0);
            chk("reach_state", 32'(state), 32'(s));
            repeat (5) step(1'b1, 1'b0);
            chk("five_ones_state", 32'(state), 32'(S_TLR));
            chk("five_ones_tlr",   32'(tlr),   32'd1);
        end

        // Reset on the 10th Shift-DR cycle.
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        repeat (9) step(1'b0, 1'b0);
        base_dr  = cnt_dr;
        upd_seen = 0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        upd_seen += int'(updateDR);
        step(1'b0, 1'b0);
        upd_seen += int'(updateDR);
        step(1'b0, 1'b0);
        chk("reset_shift_dr_pulses", 32'(cnt_dr - base_dr), 32'd1);
        chk("reset_shift_updateDR",  32'(upd_seen),         32'd0);
        chk("reset_shift_tdo_en",    32'(tdo_en),           32'd0);

        // Random tms walk with occasional resets.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
